// File: rtl/apb_cfg_slave.sv
// APB configuration responder: RW register bank, read-only status words, a W1C sticky
// event register and an ID word, with a programmable wait-state count before each ready pulse.
module apb_cfg_slave #(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [15:0] ID_VALUE    = 16'hA5C3
) (
   input  logic                     apb_clk,
   input  logic                     apb_rst,
   input  logic                     apb_sel,
   input  logic                     apb_enable,
   input  logic [7:0]               apb_addr,
   input  logic                     apb_write,
   input  logic [15:0]              apb_wdata,
   output logic                     apb_ready,
   output logic [15:0]              apb_rdata,
   output logic [16*NUM_REGS-1:0]   cfg_regs,
   output logic                     cfg_wr_pulse,
   output logic [7:0]               cfg_wr_addr,
   input  logic [63:0]              status_in,
   input  logic [15:0]              evt_in,
   output logic [1:0]               fsm_state
);

   localparam int         IDXW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0] NUM_REGS_LIM = 9'(NUM_REGS);
   localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_CYCLES);
   localparam logic [7:0] EVT_ADDR     = 8'h84;
   localparam logic [7:0] ID_ADDR      = 8'hFF;

   // fsm_state encoding: 0 = IDLE, 1 = WAIT, 2 = HOLD.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [7:0]  addr_q;
   logic        write_q;
   logic [15:0] wdata_q;
   logic [15:0] evt;
   logic [15:0] regs [NUM_REGS];

   logic        commit;
   logic        is_rw;
   logic        is_status;
   logic [15:0] rd_val;
   logic [15:0] evt_clr;
   logic [3:0][15:0] status_w;

   assign status_w  = status_in;
   assign fsm_state = state;
   assign commit    = (state == ST_WAIT) && apb_sel && (cnt == 4'd0);
   assign is_rw     = ({1'b0, addr_q} < NUM_REGS_LIM);
   assign is_status = (addr_q[7:2] == 6'b100000);

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign cfg_regs[16*k +: 16] = regs[k];
   end

   // Read mux sees the live status/event values so the read reflects the ready edge.
   always_comb begin
      rd_val = '0;
      if (is_rw) begin
         rd_val = regs[addr_q[IDXW-1:0]];
      end else if (is_status) begin
         rd_val = status_w[addr_q[1:0]];
      end else if (addr_q == EVT_ADDR) begin
         rd_val = evt;
      end else if (addr_q == ID_ADDR) begin
         rd_val = ID_VALUE;
      end
   end

   always_comb begin
      evt_clr = '0;
      if (commit && write_q && (addr_q == EVT_ADDR)) begin
         evt_clr = wdata_q;
      end
   end

   // Set is applied after clear, so a same-cycle set beats the clear.
   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         evt <= '0;
      end else begin
         evt <= (evt & ~evt_clr) | evt_in;
      end
   end

   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         apb_ready    <= 1'b0;
         apb_rdata    <= '0;
         cfg_wr_pulse <= 1'b0;
         cfg_wr_addr  <= '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         apb_ready    <= 1'b0;
         cfg_wr_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (apb_sel && apb_enable) begin
                  addr_q  <= apb_addr;
                  write_q <= apb_write;
                  wdata_q <= apb_wdata;
                  cnt     <= WAIT_LOAD;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!apb_sel) begin
                  state <= ST_IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  apb_ready <= 1'b1;
                  state     <= ST_HOLD;
                  if (write_q) begin
                     if (is_rw) begin
                        regs[addr_q[IDXW-1:0]] <= wdata_q;
                        cfg_wr_pulse           <= 1'b1;
                        cfg_wr_addr            <= addr_q;
                     end
                  end else begin
                     apb_rdata <= rd_val;
                  end
               end
            end
            ST_HOLD: begin
               // The initiator may hold sel&enable after ready; wait for sel to drop.
               if (!apb_sel) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Bench for apb_cfg_slave: three instances (0, 1 and 3 wait states) driven by directed
// steps and randomized transfers, checked against an address-map reference model.
module tb_apb_cfg_slave;

   localparam int NR = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [2:0]        sel, en;
   logic [7:0]        addr;
   logic              wr;
   logic [15:0]       wdata;
   logic [63:0]       status;
   logic [15:0]       evt_in;
   logic [2:0]        rdy, wpulse;
   logic [2:0][15:0]  rdata;
   logic [2:0][16*NR-1:0] regs;
   logic [2:0][7:0]   waddr;
   logic [2:0][1:0]   st;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] m_regs [3][NR];
   logic [15:0] m_rd   [3];
   logic [7:0]  m_wa   [3];
   logic [15:0] m_evt  [3];

   apb_cfg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0)) u_w0 (
      .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[0]), .apb_enable(en[0]),
      .apb_addr(addr), .apb_write(wr), .apb_wdata(wdata), .apb_ready(rdy[0]),
      .apb_rdata(rdata[0]), .cfg_regs(regs[0]), .cfg_wr_pulse(wpulse[0]),
      .cfg_wr_addr(waddr[0]), .status_in(status), .evt_in(evt_in), .fsm_state(st[0]));

   apb_cfg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(1)) u_w1 (
      .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[1]), .apb_enable(en[1]),
      .apb_addr(addr), .apb_write(wr), .apb_wdata(wdata), .apb_ready(rdy[1]),
      .apb_rdata(rdata[1]), .cfg_regs(regs[1]), .cfg_wr_pulse(wpulse[1]),
      .cfg_wr_addr(waddr[1]), .status_in(status), .evt_in(evt_in), .fsm_state(st[1]));

   apb_cfg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(3)) u_w3 (
      .apb_clk(clk), .apb_rst(rst), .apb_sel(sel[2]), .apb_enable(en[2]),
      .apb_addr(addr), .apb_write(wr), .apb_wdata(wdata), .apb_ready(rdy[2]),
      .apb_rdata(rdata[2]), .cfg_regs(regs[2]), .cfg_wr_pulse(wpulse[2]),
      .cfg_wr_addr(waddr[2]), .status_in(status), .evt_in(evt_in), .fsm_state(st[2]));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      // ready is seen d-dependent negedges after the access edge: wait states + 2
      return (d == 0) ? 2 : ((d == 1) ? 3 : 5);
   endfunction

   function automatic logic [255:0] pack(input int d);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) v[16*i +: 16] = m_regs[d][i];
      return v;
   endfunction

   function automatic logic [15:0] exp_read(input int d, input logic [7:0] a);
      int j;
      if (a < NR) return m_regs[d][a];
      if (a >= 8'h80 && a <= 8'h83) begin
         j = int'(a) - 128;
         return status[j*16 +: 16];
      end
      if (a == 8'h84) return m_evt[d];
      if (a == 8'hFF) return 16'hA5C3;
      return 16'h0000;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
         m_rd[d] = '0; m_wa[d] = '0; m_evt[d] = '0;
      end
   endtask

   task automatic pulse_evt(input logic [15:0] v);
      @(negedge clk); evt_in = v;
      @(negedge clk); evt_in = '0;
      for (int d = 0; d < 3; d++) m_evt[d] = m_evt[d] | v;
   endtask

   // One APB transfer on instance d; sel is dropped at the last sampling negedge.
   task automatic xfer(input int d, input logic [7:0] a, input logic w, input logic [15:0] wd,
                       input int hold, input bit setup, input string tag);
      int k;
      int extra;
      bit got;
      logic ep;
      if (setup) begin
         @(negedge clk); sel[d] = 1'b1; en[d] = 1'b0; addr = a; wr = w; wdata = wd;
      end
      @(negedge clk); sel[d] = 1'b1; en[d] = 1'b1; addr = a; wr = w; wdata = wd;
      k = 0; got = 0; ep = 1'b0;
      while (!got && k < 40) begin
         @(negedge clk); k++;
         if (rdy[d]) got = 1;
      end
      chk({tag, " latency"}, k, lat_of(d));
      if (got) begin
         if (w) begin
            if (a < NR) begin
               m_regs[d][a] = wd; m_wa[d] = a; ep = 1'b1;
            end else if (a == 8'h84) begin
               m_evt[d] = (m_evt[d] & ~wd) | evt_in;
            end
         end else begin
            m_rd[d] = exp_read(d, a);
         end
      end
      chk({tag, " rdata"}, rdata[d], m_rd[d]);
      chk({tag, " regs"}, regs[d], pack(d));
      chk({tag, " wr_pulse"}, wpulse[d], ep);
      chk({tag, " wr_addr"}, waddr[d], m_wa[d]);
      extra = 0;
      repeat (hold) begin
         @(negedge clk);
         extra += int'(rdy[d]) + int'(wpulse[d]);
      end
      if (hold > 0) chk({tag, " single pulse"}, extra, 0);
      sel[d] = 1'b0; en[d] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int d;
      int r;
      logic [7:0] a;
      logic w;
      logic [15:0] v;

      rst = 1'b1; sel = '0; en = '0; addr = '0; wr = 1'b0; wdata = '0;
      status = '0; evt_in = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst ready", rdy, 3'b000);
      chk("rst rdata", rdata[1], 16'h0);
      chk("rst regs", regs[1], '0);
      chk("rst wr_pulse", wpulse, 3'b000);
      chk("rst wr_addr", waddr[1], 8'h0);
      chk("rst state", st[1], 2'd0);

      // write then read, one wait state
      xfer(1, 8'h03, 1'b1, 16'h1234, 1, 1, "wr03");
      chk("wr03 slice", regs[1][63:48], 16'h1234);
      xfer(1, 8'h03, 1'b0, 16'h0, 1, 1, "rd03");
      chk("rd03 value", rdata[1], 16'h1234);

      // extended hold: two cycles of sel&enable after ready
      xfer(1, 8'h07, 1'b1, 16'hC0DE, 2, 1, "hold2");

      // RO and unmapped
      xfer(1, 8'hFF, 1'b0, 16'h0, 1, 1, "rdID");
      chk("rdID value", rdata[1], 16'hA5C3);
      status = 64'h1111_2222_BEEF_3333;
      xfer(1, 8'h81, 1'b0, 16'h0, 1, 1, "rd81");
      chk("rd81 value", rdata[1], 16'hBEEF);
      @(negedge clk); status = 64'h0;
      @(negedge clk);
      chk("rd81 held after status change", rdata[1], 16'hBEEF);
      xfer(1, 8'h90, 1'b1, 16'h55AA, 1, 1, "wr90");
      xfer(1, 8'h90, 1'b0, 16'h0, 1, 1, "rd90");
      chk("rd90 value", rdata[1], 16'h0000);

      // W1C collision: set wins over clear
      pulse_evt(16'h00F0);
      xfer(1, 8'h84, 1'b0, 16'h0, 1, 1, "rdevt");
      chk("rdevt value", rdata[1], 16'h00F0);
      @(negedge clk); evt_in = 16'h0010;
      for (int i = 0; i < 3; i++) m_evt[i] = m_evt[i] | 16'h0010;
      xfer(1, 8'h84, 1'b1, 16'h00F0, 1, 1, "w1c");
      @(negedge clk); evt_in = '0;
      xfer(1, 8'h84, 1'b0, 16'h0, 1, 1, "rdw1c");
      chk("rdw1c value", rdata[1], 16'h0010);

      // zero wait states, back-to-back writes with one sel=0 cycle between
      xfer(0, 8'h02, 1'b1, 16'hAAAA, 0, 0, "b2b_a");
      xfer(0, 8'h0E, 1'b1, 16'h5555, 0, 0, "b2b_b");
      chk("b2b slice a", regs[0][47:32], 16'hAAAA);
      chk("b2b slice b", regs[0][239:224], 16'h5555);

      // three wait states: one committed write, then an abort mid-WAIT
      xfer(2, 8'h05, 1'b1, 16'h0042, 1, 1, "w3wr");
      xfer(2, 8'h05, 1'b0, 16'h0, 1, 1, "w3rd");
      @(negedge clk); sel[2] = 1'b1; en[2] = 1'b0; addr = 8'h05; wr = 1'b1; wdata = 16'hDEAD;
      @(negedge clk); en[2] = 1'b1;
      @(negedge clk); sel[2] = 1'b0; en[2] = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         cnt += int'(rdy[2]) + int'(wpulse[2]);
      end
      chk("abort no ready", cnt, 0);
      chk("abort regs", regs[2], pack(2));
      chk("abort state idle", st[2], 2'd0);

      // randomized transfers on the 0- and 1-wait instances
      for (int n = 0; n < 60; n++) begin
         d = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: a = 8'($urandom_range(0, NR - 1));
            5:             a = 8'(8'h80 + $urandom_range(0, 3));
            6:             a = 8'h84;
            7:             a = 8'hFF;
            8:             a = 8'($urandom_range(0, 255));
            default:       a = 8'($urandom_range(NR, 127));
         endcase
         w = 1'($urandom_range(0, 1));
         v = 16'($urandom);
         if ($urandom_range(0, 9) < 3) pulse_evt(16'($urandom));
         status = {32'($urandom), 32'($urandom)};
         xfer(d, a, w, v, $urandom_range(0, 2), 1, "rand");
      end

      // reset mid-WAIT on the 3-wait instance
      xfer(2, 8'h06, 1'b1, 16'h7777, 1, 1, "prerst");
      xfer(2, 8'h06, 1'b0, 16'h0, 1, 1, "prerst_rd");
      @(negedge clk); sel[2] = 1'b1; en[2] = 1'b1; addr = 8'h09; wr = 1'b1; wdata = 16'h9999;
      @(negedge clk);
      @(negedge clk); rst = 1'b1; sel[2] = 1'b0; en[2] = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_reset();
      chk("midrst ready", rdy[2], 1'b0);
      chk("midrst rdata", rdata[2], 16'h0);
      chk("midrst regs", regs[2], '0);
      chk("midrst wr_pulse", wpulse[2], 1'b0);
      chk("midrst wr_addr", waddr[2], 8'h0);
      chk("midrst state", st[2], 2'd0);
      repeat (6) @(negedge clk);
      chk("postrst regs w3", regs[2], '0);
      chk("postrst regs w1", regs[1], '0);
      xfer(1, 8'h84, 1'b0, 16'h0, 1, 1, "postrst_evt");

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
